// File: rtl/operand_fetch_if.sv
// Decode / register-bank / write-back / execute bundle for the operand fetch stage.
// master = surrounding pipeline, slave = operand_fetch.
interface operand_fetch_if #(
  parameter int REG_WIDTH = 32,
  parameter int REG_COUNT = 16,
  parameter int OP_WIDTH  = 16
);
  localparam int AW = $clog2(REG_COUNT);

  logic                 in_valid;
  logic                 in_ready;
  logic [OP_WIDTH-1:0]  in_op;
  logic [AW-1:0]        in_rs1, in_rs2;
  logic                 in_use_rs1, in_use_rs2;
  logic [AW-1:0]        in_rd;
  logic                 in_wr_rd;

  logic [AW-1:0]        rf_raddr1, rf_raddr2;
  logic [REG_WIDTH-1:0] rf_rdata1, rf_rdata2;

  logic                 wb_we;
  logic [AW-1:0]        wb_waddr;
  logic [REG_WIDTH-1:0] wb_wdata;
  logic                 flush;

  logic                 out_valid;
  logic                 out_ready;
  logic [OP_WIDTH-1:0]  out_op;
  logic [REG_WIDTH-1:0] out_a, out_b;
  logic [AW-1:0]        out_rd;
  logic                 out_wr_rd;
  logic [REG_COUNT-1:0] busy_mask;

  modport master (
    output in_valid, in_op, in_rs1, in_rs2, in_use_rs1, in_use_rs2, in_rd, in_wr_rd,
    output rf_rdata1, rf_rdata2, wb_we, wb_waddr, wb_wdata, flush, out_ready,
    input  in_ready, rf_raddr1, rf_raddr2,
    input  out_valid, out_op, out_a, out_b, out_rd, out_wr_rd, busy_mask
  );

  modport slave (
    input  in_valid, in_op, in_rs1, in_rs2, in_use_rs1, in_use_rs2, in_rd, in_wr_rd,
    input  rf_rdata1, rf_rdata2, wb_we, wb_waddr, wb_wdata, flush, out_ready,
    output in_ready, rf_raddr1, rf_raddr2,
    output out_valid, out_op, out_a, out_b, out_rd, out_wr_rd, busy_mask
  );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch stage: register read, write scoreboard with RAW/WAW stall, one output register.
// Define WB_BYPASS_EN to forward same-cycle write-back data into the operands.
module operand_fetch #(
  parameter int REG_WIDTH = 32,
  parameter int REG_COUNT = 16,
  parameter int OP_WIDTH  = 16
) (
  input logic            clk,
  input logic            rst_n,
  operand_fetch_if.slave bus
);
  localparam int AW = $clog2(REG_COUNT);

  typedef struct packed {
    logic [OP_WIDTH-1:0]  op;
    logic [REG_WIDTH-1:0] a;
    logic [REG_WIDTH-1:0] b;
    logic [AW-1:0]        rd;
    logic                 wr_rd;
  } of_pkt_t;

  logic [REG_COUNT-1:0] busy, busy_nxt;
  logic                 vld;
  of_pkt_t              pkt;
  logic                 hit1, hit2, hit_rd;
  logic                 raw1, raw2, waw, accept;
  logic [REG_WIDTH-1:0] opa, opb;

  assign bus.rf_raddr1 = bus.in_rs1;
  assign bus.rf_raddr2 = bus.in_rs2;

  // WAW exemption on a same-cycle write-back holds regardless of forwarding
  assign hit_rd = bus.wb_we && (bus.wb_waddr == bus.in_rd);
`ifdef WB_BYPASS_EN
  assign hit1 = bus.wb_we && (bus.wb_waddr == bus.in_rs1);
  assign hit2 = bus.wb_we && (bus.wb_waddr == bus.in_rs2);
`else
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
`endif

  assign raw1 = bus.in_use_rs1 && busy[bus.in_rs1] && !hit1;
  assign raw2 = bus.in_use_rs2 && busy[bus.in_rs2] && !hit2;
  assign waw  = bus.in_wr_rd && busy[bus.in_rd] && !hit_rd;

  assign bus.in_ready = !bus.flush && !raw1 && !raw2 && !waw && (!vld || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  assign opa = hit1 ? bus.wb_wdata : bus.rf_rdata1;
  assign opb = hit2 ? bus.wb_wdata : bus.rf_rdata2;

  // clears first, then the new writer's set so a same-index set wins
  always_comb begin
    busy_nxt = busy;
    if (bus.wb_we) busy_nxt[bus.wb_waddr] = 1'b0;
    if (bus.flush && vld && pkt.wr_rd) busy_nxt[pkt.rd] = 1'b0;
    if (accept && bus.in_wr_rd) busy_nxt[bus.in_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld  <= 1'b0;
      pkt  <= '0;
      busy <= '0;
    end else begin
      busy <= busy_nxt;
      if (bus.flush) begin
        vld <= 1'b0;
      end else if (accept) begin
        vld <= 1'b1;
        pkt <= '{op: bus.in_op, a: opa, b: opb, rd: bus.in_rd, wr_rd: bus.in_wr_rd};
      end else if (vld && bus.out_ready) begin
        vld <= 1'b0;
      end
    end
  end

  assign bus.out_valid = vld;
  assign bus.out_op    = pkt.op;
  assign bus.out_a     = pkt.a;
  assign bus.out_b     = pkt.b;
  assign bus.out_rd    = pkt.rd;
  assign bus.out_wr_rd = pkt.wr_rd;
  assign bus.busy_mask = busy;
endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a pending-write model and per-cycle compare.
module tb_operand_fetch;
  localparam int RW = 32, RC = 16, OW = 16, AW = 4;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  operand_fetch_if #(.REG_WIDTH(RW), .REG_COUNT(RC), .OP_WIDTH(OW)) bus ();
  operand_fetch #(.REG_WIDTH(RW), .REG_COUNT(RC), .OP_WIDTH(OW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  // bench register bank: combinational read, written by write-back
  logic [RW-1:0] rf [RC];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < RC; i++) rf[i] <= RW'(32'h100 + i);
      rf[3] <= 32'h11;
      rf[4] <= 32'h22;
    end else if (bus.wb_we) begin
      rf[bus.wb_waddr] <= bus.wb_wdata;
    end
  end
  assign bus.rf_rdata1 = rf[bus.rf_raddr1];
  assign bus.rf_rdata2 = rf[bus.rf_raddr2];

  // model: set of registers with an outstanding write, plus one held instruction
  bit            pend [RC];
  bit            m_vld;
  logic [OW-1:0] m_op;
  logic [RW-1:0] m_a, m_b;
  logic [AW-1:0] m_rd;
  bit            m_wr, m_u1, m_u2;

  function automatic bit wb_to(input logic [AW-1:0] r);
    return bus.wb_we && (bus.wb_waddr == r);
  endfunction
  function automatic bit src_wait(input bit use_s, input logic [AW-1:0] r);
    return use_s && pend[r] && !(BYP && wb_to(r));
  endfunction
  function automatic bit m_ready();
    if (bus.flush) return 1'b0;
    if (src_wait(bus.in_use_rs1, bus.in_rs1) || src_wait(bus.in_use_rs2, bus.in_rs2)) return 1'b0;
    if (bus.in_wr_rd && pend[bus.in_rd] && !wb_to(bus.in_rd)) return 1'b0;
    return !m_vld || bus.out_ready;
  endfunction
  function automatic logic [RW-1:0] m_operand(input logic [AW-1:0] r);
    return (BYP && wb_to(r)) ? bus.wb_wdata : rf[r];
  endfunction
  function automatic logic [RC-1:0] pend_mask();
    logic [RC-1:0] m;
    for (int i = 0; i < RC; i++) m[i] = pend[i];
    return m;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_vld <= 1'b0;
      for (int i = 0; i < RC; i++) pend[i] <= 1'b0;
    end else begin
      bit acc;
      acc = bus.in_valid && m_ready();
      if (bus.wb_we) pend[bus.wb_waddr] <= 1'b0;
      if (bus.flush) begin
        if (m_vld && m_wr) pend[m_rd] <= 1'b0;
        m_vld <= 1'b0;
      end else if (acc) begin
        m_vld <= 1'b1;
        m_op  <= bus.in_op;
        m_a   <= m_operand(bus.in_rs1);
        m_b   <= m_operand(bus.in_rs2);
        m_rd  <= bus.in_rd;
        m_wr  <= bus.in_wr_rd;
        m_u1  <= bus.in_use_rs1;
        m_u2  <= bus.in_use_rs2;
        if (bus.in_wr_rd) pend[bus.in_rd] <= 1'b1;
      end else if (m_vld && bus.out_ready) begin
        m_vld <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready", bus.in_ready, m_ready());
    chk("busy_mask", bus.busy_mask, pend_mask());
    chk("out_valid", bus.out_valid, m_vld);
    if (m_vld) begin
      chk("out_op", bus.out_op, m_op);
      chk("out_rd", bus.out_rd, m_rd);
      chk("out_wr_rd", bus.out_wr_rd, m_wr);
      if (m_u1) chk("out_a", bus.out_a, m_a);
      if (m_u2) chk("out_b", bus.out_b, m_b);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0; bus.in_op = '0;
    bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_use_rs1 = 1'b0; bus.in_use_rs2 = 1'b0;
    bus.in_rd = '0; bus.in_wr_rd = 1'b0;
    bus.wb_we = 1'b0; bus.wb_waddr = '0; bus.wb_wdata = '0; bus.flush = 1'b0;
  endtask

  task automatic issue(input logic [OW-1:0] op, input int rs1, input bit u1, input int rs2,
                       input bit u2, input int rd, input bit wr);
    bus.in_valid = 1'b1; bus.in_op = op;
    bus.in_rs1 = AW'(rs1); bus.in_use_rs1 = u1;
    bus.in_rs2 = AW'(rs2); bus.in_use_rs2 = u2;
    bus.in_rd = AW'(rd); bus.in_wr_rd = wr;
  endtask

  initial begin
    idle();
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_busy", bus.busy_mask, 0);
    chk("rst_valid", bus.out_valid, 0);

    // independent issue R5 = f(R3, R4)
    issue(16'hA001, 3, 1, 4, 1, 5, 1);
    tick();
    chk("ind_valid", bus.out_valid, 1);
    chk("ind_a", bus.out_a, 32'h11);
    chk("ind_b", bus.out_b, 32'h22);
    chk("ind_rd", bus.out_rd, 5);
    chk("ind_busy", bus.busy_mask, 16'h0020);

    // consumer of R5 stalls until write-back
    issue(16'hA002, 5, 1, 0, 0, 6, 1);
    repeat (2) begin
      @(negedge clk); chk("raw_stall", bus.in_ready, 0);
      tick();
    end
    bus.wb_we = 1'b1; bus.wb_waddr = 4'd5; bus.wb_wdata = 32'hDEAD;
`ifdef WB_BYPASS_EN
    @(negedge clk); chk("fwd_ready", bus.in_ready, 1);
    tick();
    bus.wb_we = 1'b0;
`else
    @(negedge clk); chk("fwd_stall", bus.in_ready, 0);
    tick();
    bus.wb_we = 1'b0;
    @(negedge clk); chk("fwd_ready", bus.in_ready, 1);
    tick();
`endif
    chk("fwd_a", bus.out_a, 32'hDEAD);
    chk("fwd_busy", bus.busy_mask, 16'h0040);

    // set/clear collision on R7
    issue(16'hA003, 0, 0, 0, 0, 7, 1);
    tick();
    issue(16'hA004, 0, 0, 0, 0, 7, 1);
    bus.wb_we = 1'b1; bus.wb_waddr = 4'd7; bus.wb_wdata = 32'h77;
    @(negedge clk); chk("waw_exempt", bus.in_ready, 1);
    tick();
    idle();
    chk("set_wins", bus.busy_mask, 16'h00C0);
    chk("coll_op", bus.out_op, 16'hA004);

    // backpressure
    tick();
    bus.out_ready = 1'b0;
    issue(16'hBEEF, 3, 1, 4, 1, 8, 0);
    tick();
    issue(16'hC0DE, 4, 1, 3, 1, 8, 0);
    repeat (3) begin
      @(negedge clk);
      chk("bp_ready", bus.in_ready, 0);
      chk("bp_op", bus.out_op, 16'hBEEF);
      chk("bp_a", bus.out_a, 32'h11);
      tick();
    end
    bus.out_ready = 1'b1;
    @(negedge clk); chk("bp_release", bus.in_ready, 1);
    tick();
    idle();
    chk("bp_next_op", bus.out_op, 16'hC0DE);
    chk("bp_next_a", bus.out_a, 32'h22);

    // flush squashes a writer of R9
    tick();
    bus.out_ready = 1'b0;
    issue(16'hF009, 0, 0, 0, 0, 9, 1);
    tick();
    chk("fl_pre_busy9", bus.busy_mask[9], 1);
    issue(16'hF00A, 0, 0, 0, 0, 10, 1);
    bus.flush = 1'b1;
    @(negedge clk); chk("fl_ready", bus.in_ready, 0);
    tick();
    idle();
    chk("fl_valid", bus.out_valid, 0);
    chk("fl_busy9", bus.busy_mask[9], 0);
    chk("fl_busy10", bus.busy_mask[10], 0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("fl_noop_busy", bus.busy_mask, 16'h00C0);

    // asynchronous reset mid-stream, then 1-cycle latency
    issue(16'hE00B, 0, 0, 0, 0, 11, 1);
    tick();
    chk("pre_rst_busy11", bus.busy_mask[11], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", bus.out_valid, 0);
    chk("arst_busy", bus.busy_mask, 0);
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    issue(16'hE00C, 3, 1, 4, 1, 12, 1);
    tick();
    idle();
    chk("post_rst_valid", bus.out_valid, 1);
    chk("post_rst_a", bus.out_a, 32'h11);
    chk("post_rst_op", bus.out_op, 16'hE00C);
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Pipeline stage between instruction decode and execute.
- Drives the register bank read ports and latches the source operands, destination and opcode into one output pipeline register.
- Keeps a per-register scoreboard of writes that are issued but not yet written back. Stalls decode on RAW and WAW hazards.
- Watches the register bank write port (write-back) to clear scoreboard bits and, optionally, to forward write data.

Parameters:
- REG_WIDTH, 32, register/operand width.
- REG_COUNT, 16, number of general registers (SH-1 R0-R15).
- OP_WIDTH, 16, opaque decoded-instruction payload carried to execute.
- AW (derived, not overridable) = $clog2(REG_COUNT).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  decode has an instruction
- in_ready  out  1  stage accepts this cycle
- in_op  in  OP_WIDTH  payload
- in_rs1, in_rs2  in  AW  source register indices
- in_use_rs1, in_use_rs2  in  1  source is actually read
- in_rd  in  AW  destination index
- in_wr_rd  in  1  instruction writes rd
- rf_raddr1, rf_raddr2  out  AW  register bank read addresses
- rf_rdata1, rf_rdata2  in  REG_WIDTH  register bank read data (combinational)
- wb_we  in  1  write-back strobe (same signal as the register bank write enable)
- wb_waddr  in  AW  write-back index
- wb_wdata  in  REG_WIDTH  write-back data
- flush  in  1  discard the output register contents
- out_valid  out  1  operands valid to execute
- out_ready  in  1  execute accepts
- out_op  out  OP_WIDTH  latched payload
- out_a, out_b  out  REG_WIDTH  operand values
- out_rd  out  AW  latched destination
- out_wr_rd  out  1  latched write flag
- busy_mask  out  REG_COUNT  scoreboard, bit i = write to Ri pending

Behaviour:
Reset:
- Asynchronous reset drives out_valid=0, all out_* data=0 and busy_mask=0.
- Effect is immediate; any instruction in flight is lost.

Read addresses:
- rf_raddr1=in_rs1 and rf_raddr2=in_rs2, combinational, every cycle.

Hazard and acceptance:
- wbhit(r) = wb_we && wb_waddr==r.
- RAW(s) = use_s && busy[rs_s] && !wbhit(rs_s).
- WAW = in_wr_rd && busy[in_rd] && !wbhit(in_rd).
- in_ready = !flush && !RAW1 && !RAW2 && !WAW && (!out_valid || out_ready).
- in_ready is combinational.
- accept = in_valid && in_ready.

Operands:
- Operand value = wb_wdata if wbhit(rs), else rf_rdata.
- Unused sources still latch rf_rdata; the value is don't-care but must be deterministic.

Output register:
- Latency 1 cycle.
- On accept, at the next edge: out_valid=1 and out_op/out_a/out_b/out_rd/out_wr_rd are loaded.
- Else if out_valid && out_ready, out_valid=0.
- Otherwise hold. Data is stable while out_valid && !out_ready.

Scoreboard, per edge:
- Clear busy[wb_waddr] if wb_we.
- Then set busy[in_rd] if accept && in_wr_rd. Set wins over clear on the same index.
- wb_we to a non-busy register is legal and changes nothing.

Flush:
- Next edge: out_valid=0.
- If out_valid && out_wr_rd, busy[out_rd] is also cleared. This prevents deadlock from a squashed writer.
- No accept occurs in a flush cycle.
- Flush with out_valid=0 is a no-op.
- Instructions already handed to execute stay pending until written back.

Optional Feature:
WB_BYPASS_EN
- Defined: forwarding as described. wbhit(r) is live in both the RAW terms and the operand mux, so a source that is being written this cycle issues with wb_wdata.
- Undefined: wbhit(r) is treated as 0 in the RAW terms and the operand mux, so operands always come from rf_rdata.
  - A source whose write-back happens this cycle stalls one extra cycle, then reads the bank after the write.
  - The WAW exemption is unchanged.

Test Plan:
- Reset with stimulus active: assert rst_n=0 mid-stream -> out_valid=0 and busy_mask=0 immediately; after release, first accepted instruction latency is 1 cycle.
- Independent issue: R3=0x11, R4=0x22, in_rs1=3, in_rs2=4, in_rd=5, in_wr_rd=1, out_ready=1 -> next cycle out_a=0x11, out_b=0x22, out_rd=5, busy_mask=0x0020; a consumer of R5 then stalls (in_ready=0) until wb_we with wb_waddr=5.
- Same-cycle forward: busy[5]=1; wb_we=1, wb_waddr=5, wb_wdata=0xDEAD while an instruction reads rs1=5 ->
  - WB_BYPASS_EN defined: accepted that cycle, out_a=0xDEAD.
  - WB_BYPASS_EN undefined: in_ready=0 for one cycle, then out_a=0xDEAD read from the bank.
- Set/clear collision: busy[7]=1; wb clears R7 while an instruction with rd=7 is accepted in the same cycle -> busy[7] stays 1 (WAW exemption + set-wins).
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0 and out_* constant; out_ready=1 -> next instruction accepted the same cycle.
- Flush: out_valid=1, out_wr_rd=1, out_rd=9, busy[9]=1; assert flush -> next cycle out_valid=0, busy[9]=0, and in_valid was not accepted in the flush cycle.
